// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one single-ported memory between the CPU and a DMA engine.
// CPU has priority; DMA is forced through after MaxWait consecutive contested CPU grants.
module mem_arbiter #(
    parameter int unsigned MemLat  = 1,
    parameter int unsigned MaxWait = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        cpu_rd_i,
    input  logic        cpu_wr_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_wdata_i,
    output logic [31:0] cpu_rdata_o,
    output logic        cpu_ack_o,
    output logic        cpu_stall_o,

    input  logic        dma_rd_i,
    input  logic        dma_wr_i,
    input  logic [31:0] dma_addr_i,
    input  logic [31:0] dma_wdata_i,
    output logic [31:0] dma_rdata_o,
    output logic        dma_ack_o,

    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    localparam int unsigned CntW = $clog2(MemLat + 1);
    localparam int unsigned StW  = (MaxWait > 0) ? $clog2(MaxWait + 1) : 1;

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [StW-1:0]    starve_q, starve_d;
    logic              owner_q, owner_d;  // 1: DMA owns the current access
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [31:0]       cpu_rdata_q, cpu_rdata_d;
    logic [31:0]       dma_rdata_q, dma_rdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              dma_ack_q, dma_ack_d;

    logic cpu_req, dma_req, grant, dma_win, last;

    assign cpu_req = cpu_rd_i | cpu_wr_i;
    assign dma_req = dma_rd_i | dma_wr_i;
    assign grant   = cpu_req | dma_req;
    assign dma_win = dma_req & (~cpu_req | (starve_q >= StW'(MaxWait)));
    assign last    = (cnt_q == CntW'(1));

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (grant) state_d = StAccess;
            StAccess: if (last)  state_d = StResp;
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Datapath / output next-values
    always_comb begin
        cnt_d       = cnt_q;
        starve_d    = starve_q;
        owner_d     = owner_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        cpu_ack_d   = 1'b0;
        dma_ack_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!dma_req || dma_win) begin
                    starve_d = '0;
                end else if (starve_q < StW'(MaxWait)) begin
                    starve_d = starve_q + StW'(1);
                end
                if (grant) begin
                    owner_d = dma_win;
                    cnt_d   = CntW'(MemLat);
                    // rd and wr together decode as a write
                    if (dma_win) begin
                        mem_write_d = dma_wr_i;
                        mem_read_d  = dma_rd_i & ~dma_wr_i;
                        mem_addr_d  = dma_addr_i;
                        mem_wdata_d = dma_wdata_i;
                    end else begin
                        mem_write_d = cpu_wr_i;
                        mem_read_d  = cpu_rd_i & ~cpu_wr_i;
                        mem_addr_d  = cpu_addr_i;
                        mem_wdata_d = cpu_wdata_i;
                    end
                end
            end
            StAccess: begin
                cnt_d = cnt_q - CntW'(1);
                if (last) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    if (owner_q) begin
                        dma_ack_d = 1'b1;
                        if (mem_read_q) dma_rdata_d = mem_rdata_i;
                    end else begin
                        cpu_ack_d = 1'b1;
                        if (mem_read_q) cpu_rdata_d = mem_rdata_i;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q       <= '0;
            starve_q    <= '0;
            owner_q     <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
            owner_q     <= owner_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
            cpu_ack_q   <= cpu_ack_d;
            dma_ack_q   <= dma_ack_d;
        end
    end

    assign cpu_rdata_o = cpu_rdata_q;
    assign cpu_ack_o   = cpu_ack_q;
    assign cpu_stall_o = cpu_req & ~cpu_ack_q;
    assign dma_rdata_o = dma_rdata_q;
    assign dma_ack_o   = dma_ack_q;
    assign mem_read_o  = mem_read_q;
    assign mem_write_o = mem_write_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter (MemLat=2, MaxWait=4) with a small word memory model.
module tb_mem_arbiter;

    localparam int unsigned MemLat  = 2;
    localparam int unsigned MaxWait = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        cpu_rd = 1'b0, cpu_wr = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0, cpu_rdata;
    logic        cpu_ack, cpu_stall;
    logic        dma_rd = 1'b0, dma_wr = 1'b0;
    logic [31:0] dma_addr = '0, dma_wdata = '0, dma_rdata;
    logic        dma_ack;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int errors = 0;
    int checks = 0;
    int viol   = 0;

    logic [31:0] mem [0:255];

    always #5 clk_i = ~clk_i;

    mem_arbiter #(
        .MemLat  (MemLat),
        .MaxWait (MaxWait)
    ) u_dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .cpu_rd_i    (cpu_rd),
        .cpu_wr_i    (cpu_wr),
        .cpu_addr_i  (cpu_addr),
        .cpu_wdata_i (cpu_wdata),
        .cpu_rdata_o (cpu_rdata),
        .cpu_ack_o   (cpu_ack),
        .cpu_stall_o (cpu_stall),
        .dma_rd_i    (dma_rd),
        .dma_wr_i    (dma_wr),
        .dma_addr_i  (dma_addr),
        .dma_wdata_i (dma_wdata),
        .dma_rdata_o (dma_rdata),
        .dma_ack_o   (dma_ack),
        .mem_read_o  (mem_read),
        .mem_write_o (mem_write),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    // Memory model: combinational read, write on each strobed cycle, preload on reset
    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[8'h10] <= 32'hDEADBEEF;
            mem[8'h11] <= 32'h11112222;
        end else if (mem_write) begin
            mem[mem_addr[9:2]] <= mem_wdata;
        end
    end

    always @(negedge clk_i) begin
        if ((cpu_ack && dma_ack) || (mem_read && mem_write)) viol++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Issue one access from an IDLE cycle, wait for ack, then drop the request.
    task automatic do_access(input bit is_dma, input logic rd, input logic wr,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output logic [31:0] rdata, output int lat);
        if (is_dma) begin
            dma_rd = rd; dma_wr = wr; dma_addr = addr; dma_wdata = wdata;
        end else begin
            cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata;
        end
        lat = 0;
        @(negedge clk_i);
        while (!(is_dma ? dma_ack : cpu_ack) && lat < 20) begin
            tick();
            lat++;
            @(negedge clk_i);
        end
        rdata = is_dma ? dma_rdata : cpu_rdata;
        tick();
        if (is_dma) begin
            dma_rd = 1'b0; dma_wr = 1'b0;
        end else begin
            cpu_rd = 1'b0; cpu_wr = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd_v;
        int          lat;
        int          n;
        int          cyc;
        int          acks;
        int          reads;
        logic [31:0] exp_who [6];

        exp_who = '{0, 0, 0, 0, 1, 0};

        // Reset
        tick();
        tick();
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_cpu_ack", cpu_ack, 0);
        chk("rst_dma_ack", dma_ack, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_dma_rdata", dma_rdata, 0);
        tick();

        // Single CPU read of 0x40
        cpu_rd = 1'b1; cpu_addr = 32'h40;
        @(negedge clk_i);
        chk("t1_c0_stall", cpu_stall, 1);
        chk("t1_c0_mrd", mem_read, 0);
        tick();
        @(negedge clk_i);
        chk("t1_c1_mrd", mem_read, 1);
        chk("t1_c1_maddr", mem_addr, 32'h40);
        chk("t1_c1_stall", cpu_stall, 1);
        tick();
        @(negedge clk_i);
        chk("t1_c2_mrd", mem_read, 1);
        chk("t1_c2_ack", cpu_ack, 0);
        chk("t1_c2_stall", cpu_stall, 1);
        tick();
        @(negedge clk_i);
        chk("t1_c3_ack", cpu_ack, 1);
        chk("t1_c3_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("t1_c3_stall", cpu_stall, 0);
        chk("t1_c3_mrd", mem_read, 0);
        tick();
        cpu_rd = 1'b0;

        // Simultaneous CPU read and DMA write: CPU first, DMA follows after one IDLE
        cpu_rd = 1'b1; cpu_addr = 32'h44;
        dma_wr = 1'b1; dma_addr = 32'h80; dma_wdata = 32'hCAFEF00D;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) tick();
            if (c == 4) cpu_rd = 1'b0;
            @(negedge clk_i);
            chk($sformatf("t2_c%0d_cack", c), cpu_ack, (c == 3) ? 1 : 0);
            chk($sformatf("t2_c%0d_dack", c), dma_ack, (c == 7) ? 1 : 0);
            chk($sformatf("t2_c%0d_mwr", c), mem_write, (c == 5 || c == 6) ? 1 : 0);
            if (c == 3) chk("t2_cpu_rdata", cpu_rdata, 32'h11112222);
            if (c == 5 || c == 6) begin
                chk($sformatf("t2_c%0d_maddr", c), mem_addr, 32'h80);
                chk($sformatf("t2_c%0d_mwdata", c), mem_wdata, 32'hCAFEF00D);
            end
        end
        chk("t2_dma_rdata_kept", dma_rdata, 0);
        tick();
        dma_wr = 1'b0;

        // Starvation bound: four CPU grants, then DMA, then CPU
        cpu_rd = 1'b1; cpu_addr = 32'h40;
        dma_rd = 1'b1; dma_addr = 32'h44;
        n = 0;
        cyc = 0;
        while (n < 6 && cyc < 100) begin
            @(negedge clk_i);
            if (cpu_ack || dma_ack) begin
                chk($sformatf("t3_grant%0d", n), dma_ack ? 1 : 0, exp_who[n]);
                if (dma_ack) chk("t3_dma_rdata", dma_rdata, 32'h11112222);
                n++;
            end
            tick();
            cyc++;
        end
        cpu_rd = 1'b0; dma_rd = 1'b0;
        chk("t3_grant_count", n, 6);

        // Reset in the first ACCESS cycle of a DMA read
        dma_rd = 1'b1; dma_addr = 32'h40;
        tick();
        @(negedge clk_i);
        chk("t4_access_mrd", mem_read, 1);
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1; dma_rd = 1'b0;
        @(negedge clk_i);
        chk("t4_mem_read", mem_read, 0);
        chk("t4_mem_write", mem_write, 0);
        chk("t4_mem_addr", mem_addr, 0);
        chk("t4_mem_wdata", mem_wdata, 0);
        chk("t4_cpu_rdata", cpu_rdata, 0);
        chk("t4_dma_rdata", dma_rdata, 0);
        chk("t4_cpu_ack", cpu_ack, 0);
        acks = 0;
        reads = 0;
        for (int c = 0; c < 10; c++) begin
            if (dma_ack) acks++;
            if (mem_read) reads++;
            tick();
            @(negedge clk_i);
        end
        chk("t4_no_dma_ack", acks, 0);
        chk("t4_idle_no_read", reads, 0);
        tick();

        // Illegal rd+wr decodes as a write and leaves cpu_rdata alone
        do_access(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, rd_v, lat);
        chk("t5_pre_rdata", rd_v, 32'hDEADBEEF);
        chk("t5_pre_lat", lat, MemLat + 1);
        cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'h1234;
        tick();
        @(negedge clk_i);
        chk("t5_mwr", mem_write, 1);
        chk("t5_mrd", mem_read, 0);
        chk("t5_mwdata", mem_wdata, 32'h1234);
        tick();
        tick();
        @(negedge clk_i);
        chk("t5_ack", cpu_ack, 1);
        chk("t5_rdata_kept", cpu_rdata, 32'hDEADBEEF);
        tick();
        cpu_rd = 1'b0; cpu_wr = 1'b0;
        chk("t5_mem_stored", mem[4], 32'h1234);

        // Coherence: DMA write then CPU read of the same word
        do_access(1'b1, 1'b0, 1'b1, 32'h100, 32'hA5A5A5A5, rd_v, lat);
        chk("t6_dma_lat", lat, MemLat + 1);
        chk("t6_dma_rdata_kept", rd_v, 0);
        do_access(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, rd_v, lat);
        chk("t6_cpu_lat", lat, MemLat + 1);
        chk("t6_cpu_rdata", rd_v, 32'hA5A5A5A5);

        chk("exclusive", viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single-ported unified instruction/data memory between the multi-cycle MIPS core and a DMA/loader engine. It sits between the processor top level and the memory model. It serialises accesses, drives the memory strobes for a fixed access latency, and returns read data with a one-cycle acknowledge. It also produces a stall for the core and bounds DMA starvation under CPU priority.

## Interface
- MEM_LAT, 1: memory access latency in cycles (≥1); read data valid at end of last access cycle.
- MAX_WAIT, 4: max consecutive CPU grants while DMA is pending before DMA is forced to win (0 = DMA wins every contested arbitration).

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset; one clock, reset is synchronous and active-low.
- cpu_rd, cpu_wr  in  1 each  CPU read/write request, level, held until cpu_ack.
- cpu_addr, cpu_wdata  in  32 each  CPU address / write data.
- cpu_rdata  out  32  CPU read data, registered.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_stall  out  1  combinational: (cpu_rd|cpu_wr) & ~cpu_ack.
- dma_rd, dma_wr, dma_addr, dma_wdata, dma_rdata, dma_ack: same as the CPU set, DMA side.
- mem_read, mem_write  out  1 each  memory strobes, registered.
- mem_addr, mem_wdata  out  32 each  memory address / write data, registered.
- mem_rdata  in  32  memory read data.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any request is pending, select a winner. Latch its op, addr and wdata into mem_* registers. Load access counter with MEM_LAT and go to ACCESS. With no request, stay in IDLE with mem_read=mem_write=0.
- Arbitration priority: CPU wins, except when DMA is pending and starve_cnt ≥ MAX_WAIT, in which case DMA wins. Lone requester always wins.
- starve_cnt (width ≥ clog2(MAX_WAIT+1), saturating):
  - increments on a CPU grant while dma_rd|dma_wr is high;
  - clears on a DMA grant;
  - clears in any IDLE cycle with no DMA request.
- ACCESS:
  - hold mem_* stable and decrement the counter;
  - on counter==1, sample mem_rdata (reads only) into the winner's rdata register and go to RESP.
- RESP: pulse the winner's ack for exactly one cycle, then return to IDLE. Mem strobes deassert in RESP.
- rd and wr both high on one port is treated as a write.
- Writes leave the port's rdata unchanged. Each rdata holds its value until that port's next read completes.
- The requester must deassert (or change) its request on the edge after ack. A request still high in the following IDLE is a new access.
- The loser's request stays pending, unacked. It is re-arbitrated in the next IDLE.
- Request inputs are sampled only in IDLE. Changes during ACCESS/RESP do not affect the current access.

## Timing
- Reset (rst=0 at an edge):
  - state→IDLE;
  - mem_read, mem_write, cpu_ack, dma_ack = 0;
  - mem_addr, mem_wdata, cpu_rdata, dma_rdata = 0;
  - starve_cnt = 0.
- Reset mid-access aborts the access with no ack. Resumption is the requester's responsibility.
- Latency, for a request first seen in IDLE at cycle t:
  - mem strobes are high in cycles t+1 … t+MEM_LAT;
  - ack and valid rdata appear in cycle t+MEM_LAT+1.
- Throughput: one access per MEM_LAT+2 cycles. Back-to-back requests always pass through one IDLE cycle.
- Exactly one of cpu_ack/dma_ack can be high in any cycle. mem_read and mem_write are never high together.
- mem_* outputs change only on the IDLE→ACCESS edge (load) and the ACCESS→RESP edge (strobes clear).

## Test plan
- Single CPU read, MEM_LAT=2: cpu_rd=1, addr=0x40 at cycle 0, memory returns 0xDEADBEEF. Required: mem_read=1 in cycles 1–2; cpu_ack=1 and cpu_rdata=0xDEADBEEF in cycle 3; cpu_stall=1 in cycles 0–2 and 0 in cycle 3.
- Simultaneous CPU read and DMA write to 0x80 in cycle 0. Required: CPU served first (ack cycle 3 at MEM_LAT=2). Then DMA: mem_write=1 with addr 0x80 in cycles 5–6, dma_ack in cycle 7.
- Starvation, MAX_WAIT=4: CPU re-requests continuously while dma_rd is held. Required: exactly 4 CPU grants, then the 5th grant goes to DMA, then CPU again.
- Reset mid-access: rst=0 in the first ACCESS cycle of a DMA read. Required: next cycle all outputs are 0, no dma_ack ever pulses, and state is IDLE.
- Illegal op: cpu_rd=cpu_wr=1, wdata=0x1234. Required: mem_write=1, mem_read=0, and cpu_rdata is unchanged.
- Coherence: DMA writes 0xA5A5A5A5 to 0x100, then CPU reads 0x100. Required: cpu_rdata=0xA5A5A5A5 in the CPU ack cycle.
